// File: rtl/wash_billing_if.sv
// Bundle between the admin price-setting side and the wash_billing session
// block: prices and machine controls in, billing status back out.
interface wash_billing_if;
    logic        on;
    logic        start;
    logic [1:0]  sel;
    logic        wash_done;
    logic        pickup;
    logic [11:0] dy_price;
    logic [11:0] s_price;
    logic [11:0] m_price;
    logic [11:0] b_price;
    logic [11:0] setfine;
    logic [11:0] charge;
    logic [11:0] profit;
    logic [11:0] runtime;
    logic        busy;
    logic        fine_active;
    logic        paid;
    logic [2:0]  state;

    // Admin / machine side drives the controls and prices
    modport master (
        output on, start, sel, wash_done, pickup,
        output dy_price, s_price, m_price, b_price, setfine,
        input  charge, profit, runtime, busy, fine_active, paid, state
    );

    // Billing block consumes the controls and reports status
    modport slave (
        input  on, start, sel, wash_done, pickup,
        input  dy_price, s_price, m_price, b_price, setfine,
        output charge, profit, runtime, busy, fine_active, paid, state
    );
endinterface

// File: rtl/wash_billing.sv
// Washing machine billing: runs one customer session at a time, timing the
// wash, adding overtime fines while laundry waits, and accumulating profit
// and busy time as saturating 3-digit BCD.
module wash_billing #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int FINE_GRACE    = 10
) (
    input  logic           clk,
    input  logic           rst,
    wash_billing_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        WAIT   = 3'd2,
        SETTLE = 3'd3
    } state_t;

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);
    localparam int GR_W = (FINE_GRACE > 1) ? $clog2(FINE_GRACE) : 1;
    localparam logic [GR_W-1:0] GR_LAST = GR_W'(FINE_GRACE - 1);

    state_t           state_q;
    logic [PRE_W-1:0] presc_q;
    logic [GR_W-1:0]  grace_q;
    logic [11:0]      charge_q;
    logic [11:0]      profit_q;
    logic [11:0]      runtime_q;
    logic [11:0]      fine_q;
    logic             fine_active_q;
    logic             paid_q;
    logic [11:0]      sel_price;
    logic             sec;
    logic             start_ok;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [11:0] bcd_clamp(input logic [11:0] v);
        return {clamp_digit(v[11:8]), clamp_digit(v[7:4]), clamp_digit(v[3:0])};
    endfunction

    // Digit-wise decimal add; a carry out of the hundreds digit pins at 999
    function automatic logic [11:0] bcd_add_sat(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] sum;
        logic        carry;
        logic [4:0]  d;
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0000, carry};
            if (d > 5'd9) begin
                sum[i*4 +: 4] = 4'(d - 5'd10);
                carry         = 1'b1;
            end else begin
                sum[i*4 +: 4] = d[3:0];
                carry         = 1'b0;
            end
        end
        return carry ? 12'h999 : sum;
    endfunction

    assign sec      = bus.on && (presc_q == PRE_MAX);
    assign start_ok = bus.on && bus.start && (state_q == IDLE);

    // Pick the price for the mode requested alongside start
    always_comb begin
        sel_price = bus.dy_price;
        case (bus.sel)
            2'd1:    sel_price = bus.s_price;
            2'd2:    sel_price = bus.m_price;
            2'd3:    sel_price = bus.b_price;
            default: sel_price = bus.dy_price;
        endcase
    end

    // One-second prescaler; restarted on a session start so the first second is whole
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (bus.on) begin
            if (start_ok || presc_q == PRE_MAX) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    // Session FSM with its billing datapath; everything freezes while power is off
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            charge_q      <= '0;
            profit_q      <= '0;
            runtime_q     <= '0;
            fine_q        <= '0;
            grace_q       <= '0;
            fine_active_q <= 1'b0;
            paid_q        <= 1'b0;
        end else if (!bus.on) begin
            paid_q <= 1'b0;
        end else begin
            paid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        charge_q      <= bcd_clamp(sel_price);
                        fine_q        <= bcd_clamp(bus.setfine);
                        fine_active_q <= 1'b0;
                        grace_q       <= '0;
                        state_q       <= RUN;
                    end
                end
                RUN: begin
                    if (sec) begin
                        runtime_q <= bcd_add_sat(runtime_q, 12'h001);
                    end
                    if (bus.wash_done) begin
                        grace_q <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (sec) begin
                        runtime_q <= bcd_add_sat(runtime_q, 12'h001);
                        if (grace_q == GR_LAST) begin
                            grace_q       <= '0;
                            charge_q      <= bcd_add_sat(charge_q, fine_q);
                            fine_active_q <= 1'b1;
                        end else begin
                            grace_q <= grace_q + 1'b1;
                        end
                    end
                    if (bus.pickup) begin
                        state_q <= SETTLE;
                        paid_q  <= 1'b1;
                    end
                end
                SETTLE: begin
                    profit_q <= bcd_add_sat(profit_q, charge_q);
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.charge      = charge_q;
    assign bus.profit      = profit_q;
    assign bus.runtime     = runtime_q;
    assign bus.fine_active = fine_active_q;
    assign bus.paid        = paid_q;
    assign bus.state       = state_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_wash_billing.sv
// Scoreboard bench for wash_billing: each settled session pushes its
// hand-computed totals, and a monitor checks them when paid pulses.
module tb_wash_billing;

    typedef struct {
        logic [11:0] charge;
        logic [11:0] profit;
        logic [11:0] runtime;
        logic        fine;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb[$];

    wash_billing_if bus ();

    wash_billing #(
        .TICKS_PER_SEC(4),
        .FINE_GRACE   (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [11:0] actual, input logic [11:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_wash_done();
        bus.wash_done = 1'b1;
        @(negedge clk);
        bus.wash_done = 1'b0;
    endtask

    task automatic pulse_pickup();
        bus.pickup = 1'b1;
        @(negedge clk);
        bus.pickup = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // Wait for the monitor to consume the pending settlement, then let SETTLE finish
    task automatic wait_settled();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL settle_timeout: got %0d pending required 0", sb.size());
            sb.delete();
        end
        tick(2);
    endtask

    // One full session: r seconds in RUN, w seconds in WAIT, then pickup
    task automatic apply_stimulus(input logic [1:0] s, input int r, input int w,
                                  input logic [11:0] exp_charge, input logic exp_fine,
                                  input logic [11:0] exp_profit, input logic [11:0] exp_runtime);
        exp_t e;
        bus.sel = s;
        pulse_start();
        tick(4 * r);
        pulse_wash_done();
        if (w > 0) tick(4 * w - 1);
        e.charge  = exp_charge;
        e.profit  = exp_profit;
        e.runtime = exp_runtime;
        e.fine    = exp_fine;
        sb.push_back(e);
        pulse_pickup();
        wait_settled();
    endtask

    // Monitor: on every paid pulse, compare the session against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.paid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_paid: got paid=1 required paid=0");
                end else begin
                    e = sb.pop_front();
                    check_output("charge", bus.charge, e.charge);
                    check_output("fine_active", {11'b0, bus.fine_active}, {11'b0, e.fine});
                    @(negedge clk);
                    check_output("paid_one_cycle", {11'b0, bus.paid}, 12'h000);
                    check_output("profit", bus.profit, e.profit);
                    check_output("runtime", bus.runtime, e.runtime);
                    check_output("state_idle", {9'b0, bus.state}, 12'h000);
                    check_output("busy_low", {11'b0, bus.busy}, 12'h000);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.on        = 1'b1;
        bus.start     = 1'b0;
        bus.sel       = 2'd0;
        bus.wash_done = 1'b0;
        bus.pickup    = 1'b0;
        bus.dy_price  = 12'h000;
        bus.s_price   = 12'h000;
        bus.m_price   = 12'h000;
        bus.b_price   = 12'h000;
        bus.setfine   = 12'h000;

        $display("[TB] reset state");
        tick(2);
        rst = 1'b0;
        check_output("rst_charge", bus.charge, 12'h000);
        check_output("rst_profit", bus.profit, 12'h000);
        check_output("rst_runtime", bus.runtime, 12'h000);
        check_output("rst_busy", {11'b0, bus.busy}, 12'h000);
        check_output("rst_state", {9'b0, bus.state}, 12'h000);
        check_output("rst_paid", {11'b0, bus.paid}, 12'h000);

        $display("[TB] basic session");
        bus.m_price = 12'h035;
        apply_stimulus(2'd2, 3, 0, 12'h035, 1'b0, 12'h035, 12'h003);

        $display("[TB] overtime fines");
        reset_dut();
        bus.s_price = 12'h020;
        bus.setfine = 12'h005;
        apply_stimulus(2'd1, 1, 5, 12'h030, 1'b1, 12'h030, 12'h006);

        $display("[TB] BCD carry");
        reset_dut();
        bus.b_price  = 12'h095;
        apply_stimulus(2'd3, 0, 0, 12'h095, 1'b0, 12'h095, 12'h000);
        bus.dy_price = 12'h017;
        apply_stimulus(2'd0, 0, 0, 12'h017, 1'b0, 12'h112, 12'h000);

        $display("[TB] profit saturation and digit clamp");
        reset_dut();
        bus.m_price = 12'h495;
        apply_stimulus(2'd2, 0, 0, 12'h495, 1'b0, 12'h495, 12'h000);
        apply_stimulus(2'd2, 0, 0, 12'h495, 1'b0, 12'h990, 12'h000);
        bus.s_price = 12'h020;
        apply_stimulus(2'd1, 0, 0, 12'h020, 1'b0, 12'h999, 12'h000);
        bus.b_price = 12'h1C3;
        apply_stimulus(2'd3, 0, 0, 12'h193, 1'b0, 12'h999, 12'h000);
        bus.dy_price = 12'h998;
        bus.setfine  = 12'h005;
        apply_stimulus(2'd0, 0, 2, 12'h999, 1'b1, 12'h999, 12'h002);

        $display("[TB] snapshot, power hold and ignored start");
        reset_dut();
        bus.m_price = 12'h035;
        bus.setfine = 12'h005;
        bus.sel     = 2'd2;
        pulse_start();
        tick(2);
        bus.m_price = 12'h050;
        bus.setfine = 12'h999;
        bus.sel     = 2'd0;
        tick(2);
        check_output("run_runtime", bus.runtime, 12'h001);
        bus.on = 1'b0;
        tick(10);
        check_output("off_runtime", bus.runtime, 12'h001);
        check_output("off_state", {9'b0, bus.state}, 12'h001);
        bus.on = 1'b1;
        tick(4);
        check_output("resume_runtime", bus.runtime, 12'h002);
        pulse_wash_done();
        pulse_start();
        check_output("wait_start_state", {9'b0, bus.state}, 12'h002);
        check_output("snapshot_charge", bus.charge, 12'h035);
        begin
            exp_t e;
            e.charge  = 12'h035;
            e.profit  = 12'h035;
            e.runtime = 12'h002;
            e.fine    = 1'b0;
            sb.push_back(e);
        end
        pulse_pickup();
        wait_settled();

        $display("[TB] reset mid-session");
        reset_dut();
        bus.dy_price = 12'h040;
        bus.sel      = 2'd0;
        pulse_start();
        tick(4);
        pulse_wash_done();
        tick(3);
        check_output("wait_charge", bus.charge, 12'h040);
        check_output("wait_state", {9'b0, bus.state}, 12'h002);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_output("midrst_state", {9'b0, bus.state}, 12'h000);
        check_output("midrst_charge", bus.charge, 12'h000);
        check_output("midrst_profit", bus.profit, 12'h000);
        check_output("midrst_runtime", bus.runtime, 12'h000);
        check_output("midrst_busy", {11'b0, bus.busy}, 12'h000);
        pulse_pickup();
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wash_billing.md
Name: wash_billing

Overview:
- Consumer side of the admin price-setting interface for the washing machine.
- Takes the dry, small, medium and big prices and the overtime fine as 3-digit BCD.
- Runs one customer session: latch price, time the wash, apply overtime fines while laundry waits for pickup, then settle.
- Returns accumulated profit and runtime as 3-digit BCD to the admin display path.

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per one-second tick
FINE_GRACE, 10, seconds in WAIT per fine increment (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
on  in  1  machine power; low freezes all state and the prescaler
start  in  1  session start pulse; honoured in IDLE only
sel  in  2  mode: 0 dry, 1 small, 2 medium, 3 big
wash_done  in  1  wash-finished pulse; honoured in RUN only
pickup  in  1  customer collected laundry; honoured in WAIT only
dy_price  in  12  BCD {hundreds,tens,ones}
s_price  in  12  BCD
m_price  in  12  BCD
b_price  in  12  BCD
setfine  in  12  BCD fine per FINE_GRACE period
charge  out  12  BCD amount owed by the current session
profit  out  12  BCD accumulated takings, saturating at 999
runtime  out  12  BCD busy seconds, saturating at 999
busy  out  1  high in any state other than IDLE
fine_active  out  1  high once at least one fine has been applied in the current session
paid  out  1  one-cycle pulse on settlement
state  out  3  IDLE=0, RUN=1, WAIT=2, SETTLE=3

Behaviour:
- Reset (rst=1 at clk edge) sets state=IDLE; charge, profit, runtime=0; busy, fine_active, paid=0; prescaler=0, grace counter=0. This applies in any state, including mid-session.
- on=0: all registers hold and inputs are ignored; paid is forced to 0.
- Prescaler: counts 0..TICKS_PER_SEC-1. The sec strobe is one cycle when it wraps. The prescaler is cleared on an accepted start, so the first second is full length.
- IDLE:
  - On start, latch the price selected by sel into charge. Snapshot setfine internally. Clear fine_active and the grace counter. Next state RUN.
  - Charge is loaded the cycle after start is sampled.
  - Later changes to the price inputs or setfine do not affect the running session.
- RUN:
  - Each sec adds runtime+1 in BCD, saturating at 999.
  - On wash_done, next state WAIT; the grace counter is cleared.
  - pickup is ignored.
- WAIT:
  - Each sec increments runtime and the grace counter.
  - When the grace counter reaches FINE_GRACE: reset it to 0, set charge = charge + fine (BCD, saturating at 999), set fine_active=1.
  - On pickup, next state SETTLE. If pickup and a fine tick land in the same cycle, the fine is applied first.
- SETTLE (1 cycle): profit = profit + charge (BCD, saturating at 999), paid=1 for this cycle, next state IDLE. charge holds its value until the next start.
- start while busy is ignored. wash_done outside RUN is ignored. sel is sampled only with start.
- BCD add: digit-wise with decimal carry. A carry out of the hundreds digit gives 999.
- Input digits >9 are clamped to 9 when latched.
- busy is decoded combinationally from state, so it is high from the cycle state leaves IDLE.

Test Plan:
Use TICKS_PER_SEC=4, FINE_GRACE=2.
- Reset: hold rst for 2 cycles -> charge/profit/runtime=000, busy=0, state=0.
- Basic session: m_price=035, sel=2, start; wash_done after 3 sec; pickup immediately in WAIT -> charge=035, paid pulses once, profit=035, runtime=003, busy=0.
- Overtime fine: s_price=020, setfine=005, sel=1; wash_done after 1 sec; pickup after 5 sec in WAIT -> fines at WAIT seconds 2 and 4, charge=030, fine_active=1, profit=030 added, runtime=006.
- BCD carry and saturation:
  - profit 095 then a session of 017 -> 112.
  - From 990, a session of 020 -> 999.
  - A price digit of 0xC is latched as 9.
- Snapshot and ignore rules:
  - Change m_price 035->050 during RUN -> charge stays 035.
  - start during WAIT -> no effect.
  - on=0 for 10 cycles in RUN -> runtime frozen.
- Reset mid-session: rst during WAIT with charge=040 -> next cycle state=IDLE, profit=000, runtime=000, paid never pulses.
